// File: rtl/cv32e40p_glitch_alarm_ctrl.sv
// Glitch-sensor alarm responder: per-sensor input stage and sticky flags, threshold-in-window
// filter, halt req/ack handshake, incident counting and terminal lockdown.

module cv32e40p_glitch_alarm_sensor (
  input  logic clk,
  input  logic rst,
  input  logic alarm,
  input  logic en,
  input  logic clr,
  output logic alarm_q,
  output logic status
);

  // Set wins over a software clear landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q <= 1'b0;
      status  <= 1'b0;
    end else begin
      alarm_q <= alarm & en;
      if (alarm_q)  status <= 1'b1;
      else if (clr) status <= 1'b0;
    end
  end

endmodule

module cv32e40p_glitch_alarm_ctrl #(
  parameter int NUM_SENSORS   = 3,
  parameter int THRESHOLD     = 2,
  parameter int WINDOW        = 16,
  parameter int HOLD_CYCLES   = 8,
  parameter int MAX_INCIDENTS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SENSORS-1:0] alarm_i,
  input  logic [NUM_SENSORS-1:0] sensor_en_i,
  input  logic                   halt_ack_i,
  input  logic                   clear_i,
  output logic                   halt_req_o,
  output logic                   lockdown_o,
  output logic                   alarm_latched_o,
  output logic [NUM_SENSORS-1:0] sensor_status_o,
  output logic [7:0]             incident_cnt_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    REQ    = 3'd2,
    HALTED = 3'd3,
    HOLD   = 3'd4,
    LOCK   = 3'd5
  } state_e;

  localparam logic [3:0] THR     = 4'(THRESHOLD);
  // The opening IDLE cycle is already part of the window, so ARMED runs WINDOW-1 cycles.
  localparam logic [7:0] WIN_LD  = 8'(WINDOW - 2);
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] MAX_I   = 8'(MAX_INCIDENTS);

  state_e                 state_q, state_d;
  logic [3:0]             ev_cnt_q, ev_cnt_d, ev_inc;
  logic [7:0]             win_cnt_q, win_cnt_d;
  logic [7:0]             hold_cnt_q, hold_cnt_d;
  logic [7:0]             inc_cnt_q, inc_cnt_d, inc_sat;
  logic [NUM_SENSORS-1:0] alarm_q, status_q;
  logic                   evt, status_clr, trigger;

  assign evt        = |alarm_q;
  assign status_clr = (state_q == HALTED) && clear_i;
  assign ev_inc     = ev_cnt_q + 4'd1;
  assign inc_sat    = (inc_cnt_q == 8'hFF) ? 8'hFF : inc_cnt_q + 8'd1;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sensor
    cv32e40p_glitch_alarm_sensor u_sensor (
      .clk     (clk),
      .rst     (rst),
      .alarm   (alarm_i[i]),
      .en      (sensor_en_i[i]),
      .clr     (status_clr),
      .alarm_q (alarm_q[i]),
      .status  (status_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ev_cnt_q   <= '0;
      win_cnt_q  <= '0;
      hold_cnt_q <= '0;
      inc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ev_cnt_q   <= ev_cnt_d;
      win_cnt_q  <= win_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      inc_cnt_q  <= inc_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ev_cnt_d   = ev_cnt_q;
    win_cnt_d  = win_cnt_q;
    hold_cnt_d = hold_cnt_q;
    inc_cnt_d  = inc_cnt_q;
    trigger    = 1'b0;
    case (state_q)
      IDLE: begin
        if (evt) begin
          if (THR == 4'd1) trigger = 1'b1;
          else begin
            state_d   = ARMED;
            ev_cnt_d  = 4'd1;
            win_cnt_d = WIN_LD;
          end
        end
      end
      ARMED: begin
        if (evt && (ev_inc >= THR)) trigger = 1'b1;
        else if (win_cnt_q == 8'd0) begin
          state_d  = IDLE;
          ev_cnt_d = 4'd0;
        end else begin
          win_cnt_d = win_cnt_q - 8'd1;
          if (evt) ev_cnt_d = ev_inc;
        end
      end
      REQ:    if (halt_ack_i) state_d = HALTED;
      HALTED: begin
        if (clear_i) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == 8'd0) state_d = IDLE;
        else                    hold_cnt_d = hold_cnt_q - 8'd1;
      end
      LOCK:    ;
      default: state_d = IDLE;
    endcase
    if (trigger) begin
      inc_cnt_d = inc_sat;
      ev_cnt_d  = 4'd0;
      win_cnt_d = 8'd0;
      state_d   = (inc_sat >= MAX_I) ? LOCK : REQ;
    end
  end

  always_comb begin
    halt_req_o = 1'b0;
    lockdown_o = 1'b0;
    case (state_q)
      REQ, HALTED: halt_req_o = 1'b1;
      LOCK: begin
        halt_req_o = 1'b1;
        lockdown_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign sensor_status_o = status_q;
  assign alarm_latched_o = |status_q;
  assign incident_cnt_o  = inc_cnt_q;

endmodule
